// File: rtl/alu_exec_if.sv
// Dispatch and result bus between the reservation station and the integer execute unit.
// The execute unit uses the slave modport; the dispatching side uses master.
interface alu_exec_if #(
  parameter int ROB_W = 6,
  parameter int OP_W  = 6
);
  logic [OP_W-1:0]  alu_opcode;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_rob_index;
  logic             alu_valid;
  logic [31:0]      alu_res;
  logic [ROB_W-1:0] alu_rob_index_out;
  logic             alu_is_load;
  logic             alu_br_taken;
  logic [31:0]      alu_br_target;

  modport master (
    output alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_index,
    input  alu_valid, alu_res, alu_rob_index_out, alu_is_load, alu_br_taken, alu_br_target
  );

  modport slave (
    input  alu_opcode, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_index,
    output alu_valid, alu_res, alu_rob_index_out, alu_is_load, alu_br_taken, alu_br_target
  );
endinterface

// File: rtl/alu_exec.sv
// Two-stage pipelined integer execute unit (ALU, branch/jump, load/store address).
// Define ALU_MUL_EN to enable MUL/MULH/MULHSU/MULHU (ops 38-41); otherwise those are bubbles.
module alu_exec #(
  parameter int ROB_W = 6,
  parameter int OP_W  = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      flush,
  alu_exec_if.slave bus
);

  localparam logic [OP_W-1:0] OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE  = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11, OP_LH   = 6'd12;
  localparam logic [OP_W-1:0] OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15, OP_SB   = 6'd16;
  localparam logic [OP_W-1:0] OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19, OP_SLTI = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI  = 6'd23, OP_ANDI = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27, OP_ADD  = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31, OP_SLTU = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35, OP_OR   = 6'd36;
  localparam logic [OP_W-1:0] OP_AND  = 6'd37, OP_MUL   = 6'd38, OP_MULH = 6'd39, OP_MULHSU = 6'd40;
  localparam logic [OP_W-1:0] OP_MULHU = 6'd41;

  // Unknown opcodes never enter the pipeline, so they can never raise alu_valid.
  function automatic logic op_known(input logic [OP_W-1:0] op);
`ifdef ALU_MUL_EN
    return (op >= OP_LUI) && (op <= OP_MULHU);
`else
    return (op >= OP_LUI) && (op <= OP_AND);
`endif
  endfunction

  logic [OP_W-1:0]  op_r;
  logic [31:0]      val1_r, val2_r, imm_r, pc_r;
  logic [ROB_W-1:0] rob_r;
  logic             v1_r;

  logic             valid_r, is_load_r, br_taken_r;
  logic [31:0]      res_r, br_target_r;
  logic [ROB_W-1:0] rob_out_r;

  logic [31:0]      res_s, br_target_s, sum_vi_s, pc_imm_s;
  logic [ROB_W-1:0] rob_s;
  logic             is_load_s, br_taken_s;

  // E1: capture the dispatched op; flush drops both E1 and the incoming op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= {OP_W{1'b0}};
      val1_r <= 32'd0;
      val2_r <= 32'd0;
      imm_r  <= 32'd0;
      pc_r   <= 32'd0;
      rob_r  <= {ROB_W{1'b0}};
      v1_r   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        op_r <= {OP_W{1'b0}};
        v1_r <= 1'b0;
      end else begin
        op_r   <= bus.alu_opcode;
        val1_r <= bus.alu_val1;
        val2_r <= bus.alu_val2;
        imm_r  <= bus.alu_imm;
        pc_r   <= bus.alu_pc;
        rob_r  <= bus.alu_rob_index;
        v1_r   <= op_known(bus.alu_opcode);
      end
    end
  end

`ifdef ALU_MUL_EN
  logic [31:0] pp_ll_r, pp_lh_r, pp_hl_r, pp_hh_r;
  logic [63:0] prod_s;
  logic [31:0] hi_u_s, mulh_s, mulhsu_s;

  // E1 half of the multiplier: four unsigned 16x16 partial products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_ll_r <= 32'd0;
      pp_lh_r <= 32'd0;
      pp_hl_r <= 32'd0;
      pp_hh_r <= 32'd0;
    end else if (rdy) begin
      pp_ll_r <= {16'd0, bus.alu_val1[15:0]}  * {16'd0, bus.alu_val2[15:0]};
      pp_lh_r <= {16'd0, bus.alu_val1[15:0]}  * {16'd0, bus.alu_val2[31:16]};
      pp_hl_r <= {16'd0, bus.alu_val1[31:16]} * {16'd0, bus.alu_val2[15:0]};
      pp_hh_r <= {16'd0, bus.alu_val1[31:16]} * {16'd0, bus.alu_val2[31:16]};
    end
  end

  // Signed high words come from the unsigned product minus the sign corrections.
  assign prod_s   = {32'd0, pp_ll_r} + {16'd0, pp_lh_r, 16'd0} + {16'd0, pp_hl_r, 16'd0} + {pp_hh_r, 32'd0};
  assign hi_u_s   = prod_s[63:32];
  assign mulhsu_s = hi_u_s - (val1_r[31] ? val2_r : 32'd0);
  assign mulh_s   = mulhsu_s - (val2_r[31] ? val1_r : 32'd0);
`endif

  assign sum_vi_s = val1_r + imm_r;
  assign pc_imm_s = pc_r + imm_r;

  // E2 result computation; every sideband output is forced low for bubbles.
  always_comb begin
    res_s       = 32'd0;
    br_target_s = 32'd0;
    br_taken_s  = 1'b0;
    is_load_s   = 1'b0;
    rob_s       = {ROB_W{1'b0}};
    if (v1_r) begin
      rob_s = rob_r;
      case (op_r)
        OP_LUI:   res_s = imm_r;
        OP_AUIPC: res_s = pc_imm_s;
        OP_JAL: begin
          res_s = pc_r + 32'd4; br_taken_s = 1'b1; br_target_s = pc_imm_s;
        end
        OP_JALR: begin
          res_s = pc_r + 32'd4; br_taken_s = 1'b1; br_target_s = sum_vi_s & 32'hFFFF_FFFE;
        end
        OP_BEQ:  begin br_taken_s = (val1_r == val2_r); br_target_s = pc_imm_s; end
        OP_BNE:  begin br_taken_s = (val1_r != val2_r); br_target_s = pc_imm_s; end
        OP_BLT:  begin br_taken_s = ($signed(val1_r) <  $signed(val2_r)); br_target_s = pc_imm_s; end
        OP_BGE:  begin br_taken_s = ($signed(val1_r) >= $signed(val2_r)); br_target_s = pc_imm_s; end
        OP_BLTU: begin br_taken_s = (val1_r <  val2_r); br_target_s = pc_imm_s; end
        OP_BGEU: begin br_taken_s = (val1_r >= val2_r); br_target_s = pc_imm_s; end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
          res_s = sum_vi_s; is_load_s = 1'b1;
        end
        OP_ADDI:  res_s = sum_vi_s;
        OP_SLTI:  res_s = {31'd0, $signed(val1_r) < $signed(imm_r)};
        OP_SLTIU: res_s = {31'd0, val1_r < imm_r};
        OP_XORI:  res_s = val1_r ^ imm_r;
        OP_ORI:   res_s = val1_r | imm_r;
        OP_ANDI:  res_s = val1_r & imm_r;
        OP_SLLI:  res_s = val1_r << imm_r[4:0];
        OP_SRLI:  res_s = val1_r >> imm_r[4:0];
        OP_SRAI:  res_s = $signed(val1_r) >>> imm_r[4:0];
        OP_ADD:   res_s = val1_r + val2_r;
        OP_SUB:   res_s = val1_r - val2_r;
        OP_SLL:   res_s = val1_r << val2_r[4:0];
        OP_SLT:   res_s = {31'd0, $signed(val1_r) < $signed(val2_r)};
        OP_SLTU:  res_s = {31'd0, val1_r < val2_r};
        OP_XOR:   res_s = val1_r ^ val2_r;
        OP_SRL:   res_s = val1_r >> val2_r[4:0];
        OP_SRA:   res_s = $signed(val1_r) >>> val2_r[4:0];
        OP_OR:    res_s = val1_r | val2_r;
        OP_AND:   res_s = val1_r & val2_r;
`ifdef ALU_MUL_EN
        OP_MUL:    res_s = prod_s[31:0];
        OP_MULH:   res_s = mulh_s;
        OP_MULHSU: res_s = mulhsu_s;
        OP_MULHU:  res_s = hi_u_s;
`endif
        default:  res_s = 32'd0;
      endcase
    end else begin
      rob_s = {ROB_W{1'b0}};
    end
  end

  // E2 output registers; they hold while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r     <= 1'b0;
      res_r       <= 32'd0;
      rob_out_r   <= {ROB_W{1'b0}};
      is_load_r   <= 1'b0;
      br_taken_r  <= 1'b0;
      br_target_r <= 32'd0;
    end else if (rdy) begin
      if (flush) begin
        valid_r     <= 1'b0;
        res_r       <= 32'd0;
        rob_out_r   <= {ROB_W{1'b0}};
        is_load_r   <= 1'b0;
        br_taken_r  <= 1'b0;
        br_target_r <= 32'd0;
      end else begin
        valid_r     <= v1_r;
        res_r       <= res_s;
        rob_out_r   <= rob_s;
        is_load_r   <= is_load_s;
        br_taken_r  <= br_taken_s;
        br_target_r <= br_target_s;
      end
    end
  end

  assign bus.alu_valid         = valid_r;
  assign bus.alu_res           = res_r;
  assign bus.alu_rob_index_out = rob_out_r;
  assign bus.alu_is_load       = is_load_r;
  assign bus.alu_br_taken      = br_taken_r;
  assign bus.alu_br_target     = br_target_r;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops against a reference model.
// Expectations for ops 38-41 follow ALU_MUL_EN, matching how the design is built.
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.ROB_W(6), .OP_W(6)) bus ();

  alu_exec #(.ROB_W(6), .OP_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [5:0]  rob;
    logic        ld;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t m_e1, m_out;

  function automatic exp_t bub();
    exp_t e;
    e.v = 1'b0; e.res = 32'd0; e.rob = 6'd0; e.ld = 1'b0; e.tk = 1'b0; e.tgt = 32'd0;
    return e;
  endfunction

  // Reference result of one op, straight from the instruction semantics.
  function automatic exp_t ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] im, input logic [31:0] p, input logic [5:0] rb);
    exp_t e;
    logic [63:0] ext, sa, sb;
    e = bub();
    e.v = 1'b1;
    e.rob = rb;
    case (op)
      1: e.res = im;
      2: e.res = p + im;
      3: begin e.res = p + 32'd4; e.tk = 1'b1; e.tgt = p + im; end
      4: begin e.res = p + 32'd4; e.tk = 1'b1; e.tgt = (a + im) & 32'hFFFF_FFFE; end
      5, 6, 7, 8, 9, 10: begin
        e.tgt = p + im;
        case (op)
          5: e.tk = (a == b);
          6: e.tk = (a != b);
          7: e.tk = ($signed(a) < $signed(b));
          8: e.tk = !($signed(a) < $signed(b));
          9: e.tk = (a < b);
          default: e.tk = !(a < b);
        endcase
      end
      11, 12, 13, 14, 15, 16, 17, 18: begin e.res = a + im; e.ld = 1'b1; end
      19: e.res = a + im;
      20: e.res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
      21: e.res = (a < im) ? 32'd1 : 32'd0;
      22: e.res = a ^ im;
      23: e.res = a | im;
      24: e.res = a & im;
      25: e.res = a << im[4:0];
      26: e.res = a >> im[4:0];
      27: begin ext = {{32{a[31]}}, a} >> im[4:0]; e.res = ext[31:0]; end
      28: e.res = a + b;
      29: e.res = a - b;
      30: e.res = a << b[4:0];
      31: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      32: e.res = (a < b) ? 32'd1 : 32'd0;
      33: e.res = a ^ b;
      34: e.res = a >> b[4:0];
      35: begin ext = {{32{a[31]}}, a} >> b[4:0]; e.res = ext[31:0]; end
      36: e.res = a | b;
      37: e.res = a & b;
`ifdef ALU_MUL_EN
      38, 39, 40, 41: begin
        sa = (op == 41) ? {32'd0, a} : {{32{a[31]}}, a};
        sb = (op == 39) ? {{32{b[31]}}, b} : {32'd0, b};
        ext = sa * sb;
        e.res = (op == 38) ? ext[31:0] : ext[63:32];
      end
`endif
      default: e = bub();
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, bus.alu_valid}, {31'd0, m_out.v});
    if (m_out.v) begin
      chk("res", bus.alu_res, m_out.res);
      chk("rob", {26'd0, bus.alu_rob_index_out}, {26'd0, m_out.rob});
    end
    chk("is_load", {31'd0, bus.alu_is_load}, {31'd0, m_out.ld});
    chk("br_taken", {31'd0, bus.alu_br_taken}, {31'd0, m_out.tk});
    if (m_out.tk || !m_out.v) chk("br_target", bus.alu_br_target, m_out.tgt);
  endtask

  // One clock: present inputs, advance the model at the edge, check at the falling edge.
  task automatic step(input int op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] p, input logic [5:0] rb, input logic r, input logic f);
    bus.alu_opcode = op[5:0];
    bus.alu_val1 = a;
    bus.alu_val2 = b;
    bus.alu_imm = im;
    bus.alu_pc = p;
    bus.alu_rob_index = rb;
    rdy = r;
    flush = f;
    @(posedge clk);
    if (r) begin
      if (f) begin
        m_e1 = bub();
        m_out = bub();
      end else begin
        m_out = m_e1;
        m_e1 = ref_op(op, a, b, im, p, rb);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, b;
      int op;
      op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(42, 63)) : int'($urandom_range(0, 41));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(op, a, b, $urandom, $urandom, 6'($urandom_range(0, 63)),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    m_e1 = bub();
    m_out = bub();
    bus.alu_opcode = 6'd0; bus.alu_val1 = 32'd0; bus.alu_val2 = 32'd0;
    bus.alu_imm = 32'd0; bus.alu_pc = 32'd0; bus.alu_rob_index = 6'd0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    idle();

    // ADD 5+7 appears two edges after dispatch, for exactly one cycle
    step(28, 32'd5, 32'd7, 32'd0, 32'd0, 6'd3, 1'b1, 1'b0);
    chk("add_early", {31'd0, bus.alu_valid}, 32'd0);
    idle();
    chk("add_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("add_res", bus.alu_res, 32'd12);
    chk("add_rob", {26'd0, bus.alu_rob_index_out}, 32'd3);
    idle();
    chk("add_pulse", {31'd0, bus.alu_valid}, 32'd0);

    // signed vs unsigned less-than on the same operands
    step(7, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 6'd1, 1'b1, 1'b0);
    step(9, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 6'd2, 1'b1, 1'b0);
    chk("blt_taken", {31'd0, bus.alu_br_taken}, 32'd1);
    chk("blt_target", bus.alu_br_target, 32'h120);
    idle();
    chk("bltu_taken", {31'd0, bus.alu_br_taken}, 32'd0);

    step(13, 32'h1000, 32'd0, 32'hFFFF_FFFC, 32'd0, 6'd4, 1'b1, 1'b0);
    step(27, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 6'd5, 1'b1, 1'b0);
    chk("lw_res", bus.alu_res, 32'hFFC);
    chk("lw_is_load", {31'd0, bus.alu_is_load}, 32'd1);
    idle();
    chk("srai_res", bus.alu_res, 32'hF800_0000);
    chk("srai_is_load", {31'd0, bus.alu_is_load}, 32'd0);

    // flush on the third of three back-to-back ops
    step(28, 32'd1, 32'd2, 32'd0, 32'd0, 6'd6, 1'b1, 1'b0);
    step(4, 32'h40, 32'd0, 32'd8, 32'h200, 6'd7, 1'b1, 1'b0);
    chk("fl_add_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("fl_add_res", bus.alu_res, 32'd3);
    step(29, 32'd9, 32'd4, 32'd0, 32'd0, 6'd8, 1'b1, 1'b1);
    chk("fl_cut", {31'd0, bus.alu_valid}, 32'd0);
    idle();
    chk("fl_gap1", {31'd0, bus.alu_valid}, 32'd0);
    idle();
    chk("fl_gap2", {31'd0, bus.alu_valid}, 32'd0);

    // stall with an op sitting in E1
    step(28, 32'd10, 32'd20, 32'd0, 32'd0, 6'd9, 1'b1, 1'b0);
    repeat (3) begin
      step(28, 32'd1, 32'd1, 32'd0, 32'd0, 6'd10, 1'b0, 1'b0);
      chk("stall_valid", {31'd0, bus.alu_valid}, 32'd0);
    end
    idle();
    chk("stall_release", {31'd0, bus.alu_valid}, 32'd1);
    chk("stall_res", bus.alu_res, 32'd30);

    // multiplier family (bubbles when the multiplier is not built)
    step(39, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 6'd11, 1'b1, 1'b0);
    step(41, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 6'd12, 1'b1, 1'b0);
    step(38, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 6'd13, 1'b1, 1'b0);
`ifdef ALU_MUL_EN
    chk("mulh", bus.alu_res, 32'hFFFF_FFFF);
    idle();
    chk("mulhu", bus.alu_res, 32'h0000_0001);
    idle();
    chk("mul", bus.alu_res, 32'hFFFF_FFFE);
`else
    chk("mulh_off", {31'd0, bus.alu_valid}, 32'd0);
    idle();
    chk("mulhu_off", {31'd0, bus.alu_valid}, 32'd0);
    idle();
    chk("mul_off", {31'd0, bus.alu_valid}, 32'd0);
`endif

    rand_steps(500);

    // asynchronous reset between edges, with a result on the bus
    step(3, 32'd0, 32'd0, 32'h40, 32'h1000, 6'd14, 1'b1, 1'b0);
    idle();
    #1 rst = 1'b1;
    #1;
    m_e1 = bub();
    m_out = bub();
    check_outputs();
    chk("arst_res", bus.alu_res, 32'd0);
    chk("arst_rob", {26'd0, bus.alu_rob_index_out}, 32'd0);
    #1 rst = 1'b0;
    idle();

    rand_steps(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
